// File: rtl/gato_pkg.sv
// Shared definitions for the tic-tac-toe referee: player cell codes, FSM
// encoding and the eight winning line index triples.
package gato_pkg;

  localparam logic [1:0] CODIGO_P1 = 2'b11;
  localparam logic [1:0] CODIGO_P2 = 2'b01;

  localparam int         NUM_CELDAS  = 9;
  localparam int         NUM_LINEAS  = 8;
  localparam logic [3:0] MAX_JUGADAS = 4'd9;

  typedef enum logic [2:0] {
    INACTIVO,
    TURNO_P1,
    TURNO_P2,
    EVALUA_P1,
    EVALUA_P2,
    GANA_P1,
    GANA_P2,
    EMPATE
  } estado_t;

  typedef logic [3:0] celda_idx_t;

  // Cell indices are 0-based: c1 is index 0, c9 is index 8.
  localparam celda_idx_t LINEAS [NUM_LINEAS][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [3:0] contar(input logic [8:0][1:0] celdas,
                                        input logic [1:0]      codigo);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_CELDAS; i++) begin
      if (celdas[i] == codigo) n = n + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/detector_linea.sv
// Combinational line detector: one mask bit per board line whose three cells
// all hold the given player code.
module detector_linea
  import gato_pkg::*;
(
  input  logic [8:0][1:0] celdas_i,
  input  logic [1:0]      codigo_i,
  output logic [7:0]      mascara_o
);

  for (genvar gi = 0; gi < NUM_LINEAS; gi++) begin : g_linea
    assign mascara_o[gi] = (celdas_i[LINEAS[gi][0]] == codigo_i) &&
                           (celdas_i[LINEAS[gi][1]] == codigo_i) &&
                           (celdas_i[LINEAS[gi][2]] == codigo_i);
  end

endmodule

// File: rtl/arbitro_juego.sv
// Tic-tac-toe referee: grants turns, detects accepted moves from cell-count
// increases, evaluates each move for win/draw and holds the result.
module arbitro_juego
  import gato_pkg::estado_t, gato_pkg::contar, gato_pkg::MAX_JUGADAS,
         gato_pkg::INACTIVO, gato_pkg::TURNO_P1, gato_pkg::TURNO_P2,
         gato_pkg::EVALUA_P1, gato_pkg::EVALUA_P2, gato_pkg::GANA_P1,
         gato_pkg::GANA_P2, gato_pkg::EMPATE;
#(
  parameter logic [1:0] CODIGO_P1 = gato_pkg::CODIGO_P1,
  parameter logic [1:0] CODIGO_P2 = gato_pkg::CODIGO_P2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_inicio,
  input  logic [1:0] guarda_c1,
  input  logic [1:0] guarda_c2,
  input  logic [1:0] guarda_c3,
  input  logic [1:0] guarda_c4,
  input  logic [1:0] guarda_c5,
  input  logic [1:0] guarda_c6,
  input  logic [1:0] guarda_c7,
  input  logic [1:0] guarda_c8,
  input  logic [1:0] guarda_c9,
  output logic       turno_p1,
  output logic       turno_p2,
  output logic       clear_tablero,
  output logic       gana_p1,
  output logic       gana_p2,
  output logic       empate,
  output logic       fin_juego,
  output logic [7:0] linea_ganadora,
  output logic [3:0] jugadas
);

  logic [8:0][1:0] celdas;
  logic [3:0]      cnt_p1;
  logic [3:0]      cnt_p2;
  logic [7:0]      lineas_p1;
  logic [7:0]      lineas_p2;

  assign celdas = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                   guarda_c4, guarda_c3, guarda_c2, guarda_c1};
  assign cnt_p1 = contar(celdas, CODIGO_P1);
  assign cnt_p2 = contar(celdas, CODIGO_P2);

  detector_linea u_det_p1 (
    .celdas_i  (celdas),
    .codigo_i  (CODIGO_P1),
    .mascara_o (lineas_p1)
  );

  detector_linea u_det_p2 (
    .celdas_i  (celdas),
    .codigo_i  (CODIGO_P2),
    .mascara_o (lineas_p2)
  );

  estado_t    estado_q;
  logic [3:0] jugadas_q;
  logic [3:0] snap_p1_q;
  logic [3:0] snap_p2_q;
  logic       turno_p1_q;
  logic       turno_p2_q;
  logic       clear_q;
  logic       gana_p1_q;
  logic       gana_p2_q;
  logic       empate_q;
  logic       fin_q;
  logic [7:0] linea_q;
  logic [3:0] jugadas_inc;

  assign jugadas_inc = (jugadas_q == MAX_JUGADAS) ? MAX_JUGADAS : jugadas_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= INACTIVO;
      jugadas_q  <= 4'd0;
      snap_p1_q  <= 4'd0;
      snap_p2_q  <= 4'd0;
      turno_p1_q <= 1'b0;
      turno_p2_q <= 1'b0;
      clear_q    <= 1'b0;
      gana_p1_q  <= 1'b0;
      gana_p2_q  <= 1'b0;
      empate_q   <= 1'b0;
      fin_q      <= 1'b0;
      linea_q    <= 8'h00;
    end else begin
      clear_q <= 1'b0;
      if (boton_inicio) begin
        estado_q   <= TURNO_P1;
        clear_q    <= 1'b1;
        jugadas_q  <= 4'd0;
        snap_p1_q  <= 4'd0;
        snap_p2_q  <= 4'd0;
        turno_p1_q <= 1'b1;
        turno_p2_q <= 1'b0;
        gana_p1_q  <= 1'b0;
        gana_p2_q  <= 1'b0;
        empate_q   <= 1'b0;
        fin_q      <= 1'b0;
        linea_q    <= 8'h00;
      end else begin
        case (estado_q)
          // While the clear pulse is out the old board is still visible, so
          // its counts must not be mistaken for fresh moves.
          TURNO_P1: begin
            if (!clear_q) begin
              if (cnt_p2 > snap_p2_q) snap_p2_q <= cnt_p2;
              if (cnt_p1 > snap_p1_q) begin
                snap_p1_q  <= cnt_p1;
                jugadas_q  <= jugadas_inc;
                turno_p1_q <= 1'b0;
                estado_q   <= EVALUA_P1;
              end
            end
          end
          TURNO_P2: begin
            if (!clear_q) begin
              if (cnt_p1 > snap_p1_q) snap_p1_q <= cnt_p1;
              if (cnt_p2 > snap_p2_q) begin
                snap_p2_q  <= cnt_p2;
                jugadas_q  <= jugadas_inc;
                turno_p2_q <= 1'b0;
                estado_q   <= EVALUA_P2;
              end
            end
          end
          EVALUA_P1: begin
            if (|lineas_p1) begin
              estado_q  <= GANA_P1;
              gana_p1_q <= 1'b1;
              fin_q     <= 1'b1;
              linea_q   <= lineas_p1;
            end else if (jugadas_q == MAX_JUGADAS) begin
              estado_q <= EMPATE;
              empate_q <= 1'b1;
              fin_q    <= 1'b1;
            end else begin
              estado_q   <= TURNO_P2;
              turno_p2_q <= 1'b1;
            end
          end
          EVALUA_P2: begin
            if (|lineas_p2) begin
              estado_q  <= GANA_P2;
              gana_p2_q <= 1'b1;
              fin_q     <= 1'b1;
              linea_q   <= lineas_p2;
            end else if (jugadas_q == MAX_JUGADAS) begin
              estado_q <= EMPATE;
              empate_q <= 1'b1;
              fin_q    <= 1'b1;
            end else begin
              estado_q   <= TURNO_P1;
              turno_p1_q <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign turno_p1       = turno_p1_q;
  assign turno_p2       = turno_p2_q;
  assign clear_tablero  = clear_q;
  assign gana_p1        = gana_p1_q;
  assign gana_p2        = gana_p2_q;
  assign empate         = empate_q;
  assign fin_juego      = fin_q;
  assign linea_ganadora = linea_q;
  assign jugadas        = jugadas_q;

endmodule

// File: tb/tb_arbitro_juego.sv
// Scoreboard bench for arbitro_juego: moves push expected output snapshots,
// a negedge monitor compares them whenever a turn, clear or result appears.
module tb_arbitro_juego;

  localparam logic [1:0] X = 2'b11;
  localparam logic [1:0] O = 2'b01;

  typedef logic [18:0] snap_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       boton_inicio;
  logic [1:0] tablero [9];
  logic       turno_p1, turno_p2, clear_tablero;
  logic       gana_p1, gana_p2, empate, fin_juego;
  logic [7:0] linea_ganadora;
  logic [3:0] jugadas;

  always #5 clk = ~clk;

  arbitro_juego dut (
    .clk            (clk),
    .reset          (reset),
    .boton_inicio   (boton_inicio),
    .guarda_c1      (tablero[0]),
    .guarda_c2      (tablero[1]),
    .guarda_c3      (tablero[2]),
    .guarda_c4      (tablero[3]),
    .guarda_c5      (tablero[4]),
    .guarda_c6      (tablero[5]),
    .guarda_c7      (tablero[6]),
    .guarda_c8      (tablero[7]),
    .guarda_c9      (tablero[8]),
    .turno_p1       (turno_p1),
    .turno_p2       (turno_p2),
    .clear_tablero  (clear_tablero),
    .gana_p1        (gana_p1),
    .gana_p2        (gana_p2),
    .empate         (empate),
    .fin_juego      (fin_juego),
    .linea_ganadora (linea_ganadora),
    .jugadas        (jugadas)
  );

  int    checks   = 0;
  int    failures = 0;
  int    jug_model = 0;
  snap_t esperado [$];

  function automatic snap_t mk(input logic tp1, input logic tp2, input logic clr,
                               input logic g1, input logic g2, input logic emp,
                               input logic fin, input logic [7:0] lin,
                               input logic [3:0] jug);
    return {tp1, tp2, clr, g1, g2, emp, fin, lin, jug};
  endfunction

  // Monitor: a rising turn grant, clear pulse or result is one transaction.
  logic prev_tp1 = 1'b0, prev_tp2 = 1'b0, prev_clr = 1'b0, prev_fin = 1'b0;
  always @(negedge clk) begin
    snap_t act;
    snap_t req;
    if ((clear_tablero && !prev_clr) || (turno_p1 && !prev_tp1) ||
        (turno_p2 && !prev_tp2) || (fin_juego && !prev_fin)) begin
      act = mk(turno_p1, turno_p2, clear_tablero, gana_p1, gana_p2, empate,
               fin_juego, linea_ganadora, jugadas);
      checks++;
      if (esperado.size() == 0) begin
        failures++;
        $display("FAIL evento_inesperado actual=%h required=none", act);
      end else begin
        req = esperado.pop_front();
        if (act !== req) begin
          failures++;
          $display("FAIL evento actual=%h required=%h (tp1 tp2 clr g1 g2 emp fin linea jug)", act, req);
        end else begin
          $display("evento ok snapshot=%h jugadas=%0d", act, jugadas);
        end
      end
    end
    prev_tp1 = turno_p1;
    prev_tp2 = turno_p2;
    prev_clr = clear_tablero;
    prev_fin = fin_juego;
  end

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nombre, act, req);
    end else begin
      $display("check ok %s = %0h", nombre, act);
    end
  endtask

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic iniciar();
    boton_inicio = 1'b1;
    esperado.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'h00, 4'd0));
    ciclo();
    boton_inicio = 1'b0;
    jug_model = 0;
    ciclo();
    // the square selector clears the board on the clear pulse
    for (int i = 0; i < 9; i++) tablero[i] = 2'b00;
  endtask

  // kind: 0 next turn, 1 P1 wins, 2 P2 wins, 3 draw, 4 no response expected
  task automatic mover(input int p, input int celda, input int kind, input logic [7:0] lin);
    int espera;
    logic [3:0] j;
    espera = 0;
    while (((p == 1) ? turno_p1 : turno_p2) !== 1'b1 && espera < 20) begin
      ciclo();
      espera++;
    end
    checks++;
    if (((p == 1) ? turno_p1 : turno_p2) !== 1'b1) begin
      failures++;
      $display("FAIL turno_p%0d_timeout actual=0 required=1", p);
      return;
    end
    tablero[celda-1] = (p == 1) ? X : O;
    jug_model++;
    j = jug_model[3:0];
    case (kind)
      0: esperado.push_back((p == 1) ? mk(0, 1, 0, 0, 0, 0, 0, 8'h00, j)
                                     : mk(1, 0, 0, 0, 0, 0, 0, 8'h00, j));
      1: esperado.push_back(mk(0, 0, 0, 1, 0, 0, 1, lin, j));
      2: esperado.push_back(mk(0, 0, 0, 0, 1, 0, 1, lin, j));
      3: esperado.push_back(mk(0, 0, 0, 0, 0, 1, 1, 8'h00, j));
      default: begin
      end
    endcase
    ciclo();
  endtask

  task automatic todo_cero(input string etiqueta);
    chk({etiqueta, "_turno_p1"}, turno_p1, 0);
    chk({etiqueta, "_turno_p2"}, turno_p2, 0);
    chk({etiqueta, "_clear"}, clear_tablero, 0);
    chk({etiqueta, "_gana_p1"}, gana_p1, 0);
    chk({etiqueta, "_gana_p2"}, gana_p2, 0);
    chk({etiqueta, "_empate"}, empate, 0);
    chk({etiqueta, "_fin"}, fin_juego, 0);
    chk({etiqueta, "_linea"}, linea_ganadora, 0);
    chk({etiqueta, "_jugadas"}, jugadas, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    boton_inicio = 1'b0;
    for (int i = 0; i < 9; i++) tablero[i] = 2'b00;
    repeat (3) ciclo();
    reset = 1'b0;
    todo_cero("reset");
    repeat (2) ciclo();
    chk("idle_turno_p1", turno_p1, 0);

    // Row 1 win for P1, with an occupied-cell attempt by P2 in between
    iniciar();
    mover(1, 1, 0, 8'h00);
    mover(2, 5, 0, 8'h00);
    mover(1, 2, 0, 8'h00);
    repeat (2) ciclo();
    tablero[4] = O;
    repeat (3) ciclo();
    chk("ocupada_turno_p2", turno_p2, 1);
    chk("ocupada_jugadas", jugadas, 3);
    mover(2, 4, 0, 8'h00);
    mover(1, 3, 1, 8'h01);
    repeat (4) ciclo();
    chk("fila_gana_p1", gana_p1, 1);
    chk("fila_linea", linea_ganadora, 8'h01);
    chk("fila_jugadas", jugadas, 5);
    chk("fila_turno_p1", turno_p1, 0);
    chk("fila_turno_p2", turno_p2, 0);

    // Full board X,O,X / X,O,O / O,X,X without a line
    iniciar();
    mover(1, 1, 0, 8'h00);
    mover(2, 2, 0, 8'h00);
    mover(1, 3, 0, 8'h00);
    mover(2, 5, 0, 8'h00);
    mover(1, 4, 0, 8'h00);
    mover(2, 6, 0, 8'h00);
    mover(1, 8, 0, 8'h00);
    mover(2, 7, 0, 8'h00);
    mover(1, 9, 3, 8'h00);
    repeat (3) ciclo();
    chk("empate_flag", empate, 1);
    chk("empate_jugadas", jugadas, 9);
    chk("empate_fin", fin_juego, 1);

    // Ninth move completes the main diagonal: win beats draw
    iniciar();
    mover(1, 1, 0, 8'h00);
    mover(2, 2, 0, 8'h00);
    mover(1, 5, 0, 8'h00);
    mover(2, 3, 0, 8'h00);
    mover(1, 6, 0, 8'h00);
    mover(2, 4, 0, 8'h00);
    mover(1, 7, 0, 8'h00);
    mover(2, 8, 0, 8'h00);
    mover(1, 9, 1, 8'h40);
    repeat (3) ciclo();
    chk("diag_gana_p1", gana_p1, 1);
    chk("diag_empate", empate, 0);
    chk("diag_linea", linea_ganadora, 8'h40);
    chk("diag_jugadas", jugadas, 9);

    // P2 wins on row 2
    iniciar();
    mover(1, 1, 0, 8'h00);
    mover(2, 4, 0, 8'h00);
    mover(1, 2, 0, 8'h00);
    mover(2, 5, 0, 8'h00);
    mover(1, 9, 0, 8'h00);
    mover(2, 6, 2, 8'h02);
    repeat (3) ciclo();
    chk("p2_gana_p2", gana_p2, 1);
    chk("p2_gana_p1", gana_p1, 0);
    chk("p2_linea", linea_ganadora, 8'h02);
    chk("p2_jugadas", jugadas, 6);

    // Reset lands on the EVALUA_P2 cycle
    iniciar();
    mover(1, 1, 0, 8'h00);
    mover(2, 2, 4, 8'h00);
    reset = 1'b1;
    ciclo();
    reset = 1'b0;
    todo_cero("reset_evalua");
    repeat (3) ciclo();
    chk("reset_evalua_sigue_inactivo", turno_p1, 0);
    chk("reset_evalua_sin_fin", fin_juego, 0);

    repeat (5) ciclo();
    chk("cola_vacia", esperado.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
